// File: rtl/lsr_line_gen.sv
// -----------------------------------------------------------------------------
// lsr_line_gen
//
// Streams DATA_SIZE reconstructed line samples
//     y[i] = (intercept + slope*i) >>> shift,   i = 0 .. DATA_SIZE-1
// over a valid/ready handshake. This is the output-side partner of the
// least-squares fitter.
//
// The samples are produced incrementally. The accumulator starts at the
// sign-extended intercept and gains one sign-extended slope per accepted
// sample, so no multiplier is needed.
//
// Optional feature macro: LSR_GEN_SAT_EN
//   defined   : the shifted accumulator is saturated to the DATA_W signed range
//   undefined : the low DATA_W bits are output (two's-complement wrap)
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   start      : begin a run (sampled only while idle)
//   slope      : signed slope, same fixed-point format as intercept
//   intercept  : signed intercept
//   shift      : fractional bit count, clamped to ACC_W-1 at capture
//   y_data     : signed output sample
//   y_valid    : y_data is valid
//   y_ready    : consumer accepts the current sample
//   y_idx      : index of the current sample
//   y_last     : current sample is the final one of the run
//   busy       : a run is streaming
//   done       : one-cycle pulse after the final transfer
// -----------------------------------------------------------------------------
module lsr_line_gen #(
    parameter int DATA_SIZE = 7,
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [DATA_W-1:0]            slope,
    input  logic [DATA_W-1:0]            intercept,
    input  logic [15:0]                  shift,
    output logic [DATA_W-1:0]            y_data,
    output logic                         y_valid,
    input  logic                         y_ready,
    output logic [$clog2(DATA_SIZE):0]   y_idx,
    output logic                         y_last,
    output logic                         busy,
    output logic                         done
);

    localparam int IDX_W = $clog2(DATA_SIZE) + 1;
    localparam int SH_W  = $clog2(ACC_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [DATA_W-1:0]         slope_q, slope_d;
    logic [SH_W-1:0]           shift_q, shift_d;

    logic                      xfer_s;
    logic                      last_s;
    logic [SH_W-1:0]           shift_clamp_s;
    logic signed [ACC_W-1:0]   t_s;

    // Clamp t into the signed DATA_W range.
    function automatic logic [DATA_W-1:0] sat_to_data(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-DATA_W:0] upper;
        upper = v[ACC_W-1:DATA_W-1];
        // In range only when every bit above the DATA_W sign bit matches it.
        if (upper == {(ACC_W-DATA_W+1){1'b0}} || upper == {(ACC_W-DATA_W+1){1'b1}}) begin
            sat_to_data = v[DATA_W-1:0];
        end else if (v[ACC_W-1] == 1'b0) begin
            sat_to_data = {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            sat_to_data = {1'b1, {(DATA_W-1){1'b0}}};
        end
    endfunction

    assign xfer_s = (state_q == ST_RUN) && y_ready;
    assign last_s = (idx_q == IDX_W'(DATA_SIZE - 1));

    // The shift amount is clamped once at capture, so the output path only
    // ever sees a legal shift.
    assign shift_clamp_s = (shift > 16'(ACC_W - 1)) ? SH_W'(ACC_W - 1) : shift[SH_W-1:0];

    assign t_s = acc_q >>> shift_q;

    // Output reduction: saturating or wrapping, selected at build time.
`ifdef LSR_GEN_SAT_EN
    assign y_data = sat_to_data(t_s);
`else
    assign y_data = DATA_W'(t_s);
`endif

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            slope_q <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            slope_q <= slope_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (xfer_s && last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: capture on start, step the accumulator on each transfer.
    always_comb begin
        acc_d   = acc_q;
        idx_d   = idx_q;
        slope_d = slope_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // The intercept lives on only as the accumulator seed.
                    slope_d = slope;
                    shift_d = shift_clamp_s;
                    acc_d   = {{(ACC_W-DATA_W){intercept[DATA_W-1]}}, intercept};
                    idx_d   = '0;
                end else begin
                    acc_d   = acc_q;
                end
            end
            ST_RUN: begin
                if (xfer_s) begin
                    acc_d = acc_q + {{(ACC_W-DATA_W){slope_q[DATA_W-1]}}, slope_q};
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    acc_d = acc_q;
                end
            end
            default: begin
                acc_d = acc_q;
            end
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        y_valid = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        y_last  = 1'b0;
        case (state_q)
            ST_RUN: begin
                y_valid = 1'b1;
                busy    = 1'b1;
                y_last  = last_s;
            end
            ST_DONE: done = 1'b1;
            default: begin
                y_valid = 1'b0;
            end
        endcase
    end

    assign y_idx = idx_q;

endmodule

// File: tb/tb_lsr_line_gen.sv
module tb_lsr_line_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] slope;
    logic [15:0] intercept;
    logic [15:0] shift;
    logic [15:0] y_data;
    logic        y_valid;
    logic        y_ready;
    logic [2:0]  y_idx;
    logic        y_last;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int exp_y[7];

    lsr_line_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .slope     (slope),
        .intercept (intercept),
        .shift     (shift),
        .y_data    (y_data),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .y_idx     (y_idx),
        .y_last    (y_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Start a run, walk all samples (optionally stalling), and check the done timing.
    task automatic run_line(input logic [15:0] sl, input logic [15:0] ic, input logic [15:0] sh,
                            input int stall_at, input int stall_n, input bit poke_start,
                            input string nm);
        int i;
        int cyc;
        int stalled;
        slope = sl; intercept = ic; shift = sh; y_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Later input changes must not disturb the captured run.
        slope = 16'h5A5A; intercept = 16'hA5A5; shift = 16'd3;
        i = 0; cyc = 1; stalled = 0;
        while (i < 7 && cyc < 40) begin
            y_ready = !(i == stall_at && stalled < stall_n);
            checks++;
            if (y_valid !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s valid/busy idx %0d: got %b/%b want 1/1", nm, i, y_valid, busy);
            end
            checks++;
            if (y_data !== 16'(exp_y[i])) begin
                errors++;
                $display("FAIL %s y_data idx %0d: got %0d want %0d", nm, i, $signed(y_data), exp_y[i]);
            end
            checks++;
            if (y_idx !== 3'(i)) begin
                errors++;
                $display("FAIL %s y_idx: got %0d want %0d", nm, y_idx, i);
            end
            checks++;
            if (y_last !== (i == 6)) begin
                errors++;
                $display("FAIL %s y_last idx %0d: got %b want %b", nm, i, y_last, (i == 6));
            end
            if (!y_ready && poke_start && stalled == 0) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (y_ready) i++; else stalled++;
            cyc++;
        end
        y_ready = 1'b1;
        checks++;
        if (done !== 1'b1 || cyc != 8 + stall_n) begin
            errors++;
            $display("FAIL %s done timing: got done=%b at cycle %0d want done=1 at cycle %0d",
                     nm, done, cyc, 8 + stall_n);
        end
        checks++;
        if (y_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s valid/busy in done: got %b/%b want 0/0", nm, y_valid, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || y_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s after done: got done=%b valid=%b want 0/0", nm, done, y_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; y_ready = 1'b1;
        slope = 16'd0; intercept = 16'd0; shift = 16'd0;
        #12;
        checks++;
        if ({y_valid, busy, done, y_last} !== 4'b0000 || y_data !== 16'd0 || y_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset outputs: got v=%b b=%b d=%b l=%b data=%h idx=%0d want all 0",
                     y_valid, busy, done, y_last, y_data, y_idx);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (y_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset idle: got v=%b d=%b want 0/0", y_valid, done);
        end
    endtask

    task automatic test_integer();
        exp_y = '{1, 3, 5, 7, 9, 11, 13};
        run_line(16'd2, 16'd1, 16'd0, -1, 0, 1'b0, "integer");
    endtask

    task automatic test_fractional();
        exp_y = '{1, 1, 2, 2, 3, 3, 4};
        run_line(16'h0080, 16'h0100, 16'd8, -1, 0, 1'b0, "fractional");
    endtask

    task automatic test_negative();
        exp_y = '{0, -2, -3, -5, -6, -8, -9};
        run_line(-16'sd3, 16'd0, 16'd1, -1, 0, 1'b0, "negative");
    endtask

    task automatic test_back_to_back();
        exp_y = '{1, 3, 5, 7, 9, 11, 13};
        run_line(16'd2, 16'd1, 16'd0, -1, 0, 1'b0, "b2b_first");
        exp_y = '{0, -2, -3, -5, -6, -8, -9};
        run_line(-16'sd3, 16'd0, 16'd1, -1, 0, 1'b0, "b2b_second");
    endtask

    task automatic test_backpressure();
        exp_y = '{1, 3, 5, 7, 9, 11, 13};
        run_line(16'd2, 16'd1, 16'd0, 2, 3, 1'b1, "backpressure");
        @(posedge clk); #1;
        checks++;
        if (y_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start: got valid=%b busy=%b want 0/0", y_valid, busy);
        end
    endtask

    task automatic test_saturation();
`ifdef LSR_GEN_SAT_EN
        exp_y = '{32767, 32767, 32767, 32767, 32767, 32767, 32767};
`else
        exp_y = '{32767, -2, 32765, -4, 32763, -6, 32761};
`endif
        run_line(16'h7FFF, 16'h7FFF, 16'd0, -1, 0, 1'b0, "saturation");
    endtask

    task automatic test_shift_clamp();
        // shift 100 clamps to 31: intercept -1 stays -1, positive values floor to 0.
        exp_y = '{-1, -1, -1, -1, -1, -1, -1};
        run_line(16'd0, 16'hFFFF, 16'd100, -1, 0, 1'b0, "shift_clamp");
    endtask

    task automatic test_reset_midrun();
        int seen_done;
        slope = 16'd2; intercept = 16'd1; shift = 16'd0; y_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (y_idx !== 3'd3 || y_data !== 16'd7) begin
            errors++;
            $display("FAIL midrun pre-reset: got idx=%0d data=%0d want 3/7", y_idx, y_data);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({y_valid, busy, done, y_last} !== 4'b0000 || y_data !== 16'd0 || y_idx !== 3'd0) begin
            errors++;
            $display("FAIL midrun async reset: got v=%b b=%b d=%b l=%b data=%h idx=%0d want all 0",
                     y_valid, busy, done, y_last, y_data, y_idx);
        end
        seen_done = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (done || y_valid) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL midrun no_done: got %0d cycles with done/valid want 0", seen_done);
        end
        exp_y = '{1, 3, 5, 7, 9, 11, 13};
        run_line(16'd2, 16'd1, 16'd0, -1, 0, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_integer();
        test_fractional();
        test_negative();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_shift_clamp();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
